lm32_fwft_fifo: RTL and testbench

- Synchronous first-word-fall-through FIFO controller. It drives a registered-read-address dual-port RAM (storage sub-module) and adds the pointer, occupancy and output-prefetch logic around it.
- It sits upstream of consumers that need the head word on rd_data_o without a read-latency bubble, such as the UART/debug byte streams and instruction-fill buffering.
- Sustains one write and one read per clock.

---
 rtl/lm32_fifo_pkg.sv | 37 +++
 rtl/lm32_fifo_mem.sv | 34 +++
 rtl/lm32_fwft_fifo.sv | 122 ++++++++++++
 tb/tb_lm32_fwft_fifo.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lm32_fifo_pkg.sv
// Shared constants, widths and output-stage occupancy encoding for the
// lm32 first-word-fall-through FIFO.
package lm32_fifo_pkg;

   // Number of words held by a RAM with aw address bits
   function automatic int fifo_depth(input int aw);
      return 1 << aw;
   endfunction

   // Pointers carry one extra wrap bit so "all slots unfetched" stays distinct from "none"
   function automatic int ptr_width(input int aw);
      return aw + 1;
   endfunction

   // Occupancy spans 0..DEPTH inclusive
   function automatic int cnt_width(input int aw);
      return aw + 1;
   endfunction

   // Output stage holds at most two words: head and skid
   typedef enum logic [1:0] {
      OUT_EMPTY = 2'd0,
      OUT_ONE   = 2'd1,
      OUT_TWO   = 2'd2
   } occ_e;

   // One more word in the output stage
   function automatic occ_e occ_inc(input occ_e o);
      return (o == OUT_EMPTY) ? OUT_ONE : OUT_TWO;
   endfunction

   // One fewer word in the output stage
   function automatic occ_e occ_dec(input occ_e o);
      return (o == OUT_TWO) ? OUT_ONE : OUT_EMPTY;
   endfunction

endpackage

// File: rtl/lm32_fifo_mem.sv
// Simple dual-port storage: synchronous write, registered read address,
// read data driven combinationally from the registered address. Contents
// are never reset.
module lm32_fifo_mem
   import lm32_fifo_pkg::*;
#(
   parameter int data_width = 32,
   parameter int addr_width = 4
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [addr_width-1:0] waddr_i,
   input  logic [data_width-1:0] wdata_i,
   input  logic                  re_i,
   input  logic [addr_width-1:0] raddr_i,
   output logic [data_width-1:0] rdata_o
);

   logic [data_width-1:0] mem [fifo_depth(addr_width)];
   logic [addr_width-1:0] raddr_p0;

   // Write port
   always_ff @(posedge clk_i) begin
      if (we_i) mem[waddr_i] <= wdata_i;
   end

   // Read address register; data for a read issued this cycle appears next cycle
   always_ff @(posedge clk_i) begin
      if (re_i) raddr_p0 <= raddr_i;
   end

   assign rdata_o = mem[raddr_p0];

endmodule

// File: rtl/lm32_fwft_fifo.sv
// First-word-fall-through FIFO controller: write/fetch pointers, occupancy,
// error pulses and a two-entry output stage (head + skid) that prefetches
// from the registered-read RAM so the head word is always a register.
module lm32_fwft_fifo
   import lm32_fifo_pkg::*;
#(
   parameter int data_width = 32,
   parameter int addr_width = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  flush_i,
   input  logic                  wr_en_i,
   input  logic [data_width-1:0] wr_data_i,
   output logic                  full_o,
   input  logic                  rd_en_i,
   output logic [data_width-1:0] rd_data_o,
   output logic                  empty_o,
   output logic [addr_width:0]   count_o,
   output logic                  overflow_o,
   output logic                  underflow_o
);

   localparam int PTR_W = ptr_width(addr_width);
   localparam int CNT_W = cnt_width(addr_width);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(fifo_depth(addr_width));

   logic [PTR_W-1:0]      wr_ptr, fetch_ptr;
   logic [CNT_W-1:0]      count, count_nxt;
   logic                  full_q, ovf_q, unf_q;
   occ_e                  occ, occ_nxt;
   logic                  vld_p1;
   logic [data_width-1:0] head_p2, skid_p2, ram_rdata;
   logic                  push_acc, pop_acc, fetch_go, stage_room;
   logic [2:0]            lvl;

   assign push_acc = wr_en_i & ~full_q;
   assign pop_acc  = rd_en_i & (occ != OUT_EMPTY);

   // Words already committed to the output stage (held or arriving)
   assign lvl        = {1'b0, occ} + {2'b0, vld_p1};
   assign stage_room = (lvl < 3'd2) | (pop_acc & (lvl == 3'd2));
   // Extended pointers differ exactly when some written slot is still unfetched
   assign fetch_go   = (wr_ptr != fetch_ptr) & stage_room & ~flush_i;

   assign count_nxt  = count + CNT_W'(push_acc) - CNT_W'(pop_acc);

   // Output-stage occupancy after this edge: a pop leaves, an arriving fetch enters
   always_comb begin
      occ_nxt = occ;
      case ({pop_acc, vld_p1})
         2'b10:   occ_nxt = occ_dec(occ);
         2'b01:   occ_nxt = occ_inc(occ);
         default: occ_nxt = occ;
      endcase
   end

   lm32_fifo_mem #(
      .data_width (data_width),
      .addr_width (addr_width)
   ) u_mem (
      .clk_i   (clk_i),
      .we_i    (push_acc & ~flush_i),
      .waddr_i (wr_ptr[addr_width-1:0]),
      .wdata_i (wr_data_i),
      .re_i    (fetch_go),
      .raddr_i (fetch_ptr[addr_width-1:0]),
      .rdata_o (ram_rdata)
   );

   // Control state: pointers, occupancy, fetch-in-flight flag, status and error pulses
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr    <= '0;
         fetch_ptr <= '0;
         count     <= '0;
         full_q    <= 1'b0;
         occ       <= OUT_EMPTY;
         vld_p1    <= 1'b0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
      end else if (flush_i) begin
         wr_ptr    <= '0;
         fetch_ptr <= '0;
         count     <= '0;
         full_q    <= 1'b0;
         occ       <= OUT_EMPTY;
         vld_p1    <= 1'b0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
      end else begin
         if (push_acc) wr_ptr <= wr_ptr + 1'b1;
         if (fetch_go) fetch_ptr <= fetch_ptr + 1'b1;
         count  <= count_nxt;
         full_q <= (count_nxt == FULL_CNT);
         occ    <= occ_nxt;
         vld_p1 <= fetch_go;
         ovf_q  <= wr_en_i & full_q;
         unf_q  <= rd_en_i & (occ == OUT_EMPTY);
      end
   end

   // ---- stage p2: output registers loaded from RAM data fetched in p1 ----
   // Head/skid data: pop shifts skid into head, an arriving word fills the first free slot
   always_ff @(posedge clk_i) begin
      if (pop_acc && occ == OUT_TWO) begin
         head_p2 <= skid_p2;
         if (vld_p1) skid_p2 <= ram_rdata;
      end else if (vld_p1) begin
         if (occ == OUT_EMPTY || pop_acc) head_p2 <= ram_rdata;
         else                             skid_p2 <= ram_rdata;
      end
   end

   assign rd_data_o   = head_p2;
   assign empty_o     = (occ == OUT_EMPTY);
   assign full_o      = full_q;
   assign count_o     = count;
   assign overflow_o  = ovf_q;
   assign underflow_o = unf_q;

endmodule

// File: tb/tb_lm32_fwft_fifo.sv
// Testbench for lm32_fwft_fifo: vector table, directed corner sequences and
// a randomized run against a queue-based reference model.
module tb_lm32_fwft_fifo;

   localparam int DW = 32;
   localparam int AW = 4;
   localparam int DEPTH = 16;

   logic          clk_i = 1'b0;
   logic          rst_n_i = 1'b0;
   logic          flush_i = 1'b0;
   logic          wr_en_i = 1'b0;
   logic [DW-1:0] wr_data_i = '0;
   logic          full_o;
   logic          rd_en_i = 1'b0;
   logic [DW-1:0] rd_data_o;
   logic          empty_o;
   logic [AW:0]   count_o;
   logic          overflow_o;
   logic          underflow_o;

   int tests = 0;
   int fails = 0;

   lm32_fwft_fifo #(.data_width(DW), .addr_width(AW)) dut (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .flush_i     (flush_i),
      .wr_en_i     (wr_en_i),
      .wr_data_i   (wr_data_i),
      .full_o      (full_o),
      .rd_en_i     (rd_en_i),
      .rd_data_o   (rd_data_o),
      .empty_o     (empty_o),
      .count_o     (count_o),
      .overflow_o  (overflow_o),
      .underflow_o (underflow_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        wr;
      logic [31:0] wd;
      logic        rd;
      logic        e_empty;
      logic        e_full;
      logic [4:0]  e_cnt;
      logic        chk_d;
      logic [31:0] e_data;
      logic        e_ovf;
      logic        e_unf;
   } vec_t;

   vec_t tbl[9];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic wr, input logic [31:0] wd, input logic rd);
      wr_en_i   = wr;
      wr_data_i = wd;
      rd_en_i   = rd;
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      drive(1'b0, '0, 1'b0);
      flush_i = 1'b0;
      rst_n_i = 1'b0;
      tick();
      tick();
      rst_n_i = 1'b1;
      tick();
   endtask

   task automatic fill16(input logic [31:0] base);
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, base + i, 1'b0);
         tick();
      end
      drive(1'b0, '0, 1'b0);
   endtask

   // Seven words queued, then one pop so a fetch is in flight afterwards
   task automatic setup_seven();
      do_reset();
      for (int i = 0; i < 7; i++) begin
         drive(1'b1, 32'h7700 + i, 1'b0);
         tick();
      end
      drive(1'b0, '0, 1'b0);
      tick(); tick(); tick();
      drive(1'b0, '0, 1'b1);
      tick();
      drive(1'b0, '0, 1'b0);
   endtask

   task automatic post_clear_push(input string tag);
      drive(1'b1, 32'h1234, 1'b0);
      tick();
      check({tag, "_empty_k"}, empty_o, 1'b1);
      drive(1'b0, '0, 1'b0);
      tick();
      check({tag, "_empty_k1"}, empty_o, 1'b1);
      tick();
      check({tag, "_empty_k2"}, empty_o, 1'b0);
      check({tag, "_data"}, rd_data_o, 32'h1234);
      check({tag, "_count"}, count_o, 5'd1);
   endtask

   logic [31:0] q[$];
   int          pushed, popped, stall, cyc;
   logic        w, r, mfull, exp_ovf, exp_unf;
   logic [31:0] d, hd;

   initial begin
      // Reset through a single push/pop sequence, including push+pop at count 1
      tbl[0] = '{1'b1, 32'hA5A50001, 1'b0, 1'b1, 1'b0, 5'd1, 1'b0, 32'h0,        1'b0, 1'b0};
      tbl[1] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 5'd1, 1'b0, 32'h0,        1'b0, 1'b0};
      tbl[2] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 32'hA5A50001, 1'b0, 1'b0};
      tbl[3] = '{1'b1, 32'h00000002, 1'b1, 1'b1, 1'b0, 5'd1, 1'b0, 32'h0,        1'b0, 1'b0};
      tbl[4] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 5'd1, 1'b0, 32'h0,        1'b0, 1'b0};
      tbl[5] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 32'h00000002, 1'b0, 1'b0};
      tbl[6] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 32'h0,        1'b0, 1'b0};
      tbl[7] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 32'h0,        1'b0, 1'b1};
      tbl[8] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 32'h0,        1'b0, 1'b0};

      do_reset();
      check("reset_empty", empty_o, 1'b1);
      check("reset_full", full_o, 1'b0);
      check("reset_count", count_o, 5'd0);
      check("reset_ovf", overflow_o, 1'b0);
      check("reset_unf", underflow_o, 1'b0);

      for (int i = 0; i < 9; i++) begin
         drive(tbl[i].wr, tbl[i].wd, tbl[i].rd);
         tick();
         check($sformatf("vec%0d_empty", i), empty_o, tbl[i].e_empty);
         check($sformatf("vec%0d_full", i), full_o, tbl[i].e_full);
         check($sformatf("vec%0d_count", i), count_o, tbl[i].e_cnt);
         check($sformatf("vec%0d_ovf", i), overflow_o, tbl[i].e_ovf);
         check($sformatf("vec%0d_unf", i), underflow_o, tbl[i].e_unf);
         if (tbl[i].chk_d) check($sformatf("vec%0d_data", i), rd_data_o, tbl[i].e_data);
      end
      drive(1'b0, '0, 1'b0);

      // Fill, overflow, then drain at full rate and underflow
      do_reset();
      fill16(32'h0);
      check("fill_full", full_o, 1'b1);
      check("fill_count", count_o, 5'd16);
      drive(1'b1, 32'hDEADBEEF, 1'b0);
      tick();
      check("ovf_pulse", overflow_o, 1'b1);
      check("ovf_count", count_o, 5'd16);
      drive(1'b0, '0, 1'b0);
      tick();
      check("ovf_clear", overflow_o, 1'b0);
      tick();
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b0, '0, 1'b1);
         check($sformatf("drain%0d_empty", i), empty_o, 1'b0);
         check($sformatf("drain%0d_data", i), rd_data_o, 32'(i));
         tick();
      end
      check("drain_empty_after", empty_o, 1'b1);
      check("drain_count", count_o, 5'd0);
      check("drain_unf_quiet", underflow_o, 1'b0);
      tick();
      check("drain_unf_pulse", underflow_o, 1'b1);
      drive(1'b0, '0, 1'b0);
      tick();
      check("drain_unf_clear", underflow_o, 1'b0);

      // Push and pop together at full: pop wins, push rejected
      do_reset();
      fill16(32'h100);
      tick(); tick(); tick();
      drive(1'b1, 32'hBADBAD00, 1'b1);
      tick();
      check("fullpp_ovf", overflow_o, 1'b1);
      check("fullpp_full", full_o, 1'b0);
      check("fullpp_count", count_o, 5'd15);
      for (int i = 1; i < DEPTH; i++) begin
         drive(1'b0, '0, 1'b1);
         check($sformatf("fullpp_data%0d", i), rd_data_o, 32'h100 + i);
         tick();
      end
      drive(1'b0, '0, 1'b0);
      check("fullpp_empty_end", empty_o, 1'b1);
      check("fullpp_count_end", count_o, 5'd0);

      // Flush with words queued and a fetch in flight; flush beats a same-cycle push
      setup_seven();
      flush_i = 1'b1;
      drive(1'b1, 32'hBAD0F00D, 1'b1);
      tick();
      flush_i = 1'b0;
      drive(1'b0, '0, 1'b0);
      check("flush_empty", empty_o, 1'b1);
      check("flush_count", count_o, 5'd0);
      check("flush_full", full_o, 1'b0);
      post_clear_push("flush");

      // Asynchronous reset asserted between edges
      setup_seven();
      #3;
      rst_n_i = 1'b0;
      #1;
      check("areset_empty", empty_o, 1'b1);
      check("areset_count", count_o, 5'd0);
      check("areset_full", full_o, 1'b0);
      tick();
      rst_n_i = 1'b1;
      post_clear_push("areset");

      // Randomized traffic against a queue model
      do_reset();
      q.delete();
      pushed = 0; popped = 0; stall = 0; cyc = 0;
      while (popped < 40 && cyc < 3000) begin
         w = (pushed < 40) && ($urandom_range(0, 2) != 0);
         d = $urandom;
         r = ($urandom_range(0, 3) != 0);
         drive(w, d, r);
         mfull   = (q.size() == DEPTH);
         exp_ovf = w && mfull;
         exp_unf = r && empty_o;
         if (q.size() == 0) check("rand_empty_when_model_empty", empty_o, 1'b1);
         if (q.size() != 0 && empty_o) stall++;
         else stall = 0;
         if (stall > 2) begin
            tests++; fails++;
            $display("FAIL rand_liveness: empty for %0d cycles with %0d words queued", stall, q.size());
            stall = 0;
         end
         if (r && !empty_o) begin
            if (q.size() == 0) begin
               tests++; fails++;
               $display("FAIL rand_pop_model_empty: got word %0h expected none", rd_data_o);
            end else begin
               hd = q.pop_front();
               check("rand_data", rd_data_o, hd);
               popped++;
            end
         end
         if (w && !mfull) begin
            q.push_back(d);
            pushed++;
         end
         tick();
         check("rand_count", count_o, 5'(q.size()));
         check("rand_full", full_o, q.size() == DEPTH);
         check("rand_ovf", overflow_o, exp_ovf);
         check("rand_unf", underflow_o, exp_unf);
         cyc++;
      end
      drive(1'b0, '0, 1'b0);
      check("rand_all_popped", popped, 40);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
